// File: rtl/ex_mem_stage_pkg.sv
// Shared types and constants for the EX->MEM stage: status bit positions, exception
// cause codes, the stage FSM states, the packed pipeline entry and the fault decoder.
package ex_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int STATUS_W   = 8;
  localparam int REG_ADDR_W = 5;

  localparam int ST_RSV0  = 0;
  localparam int ST_RSV1  = 1;
  localparam int ST_DIVZ  = 2;
  localparam int ST_INVA  = 3;
  localparam int ST_NEG   = 4;
  localparam int ST_CARRY = 5;
  localparam int ST_OVF   = 6;
  localparam int ST_ZERO  = 7;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_OVF  = 3'd1;
  localparam logic [2:0] EXC_LMIS = 3'd2;
  localparam logic [2:0] EXC_SMIS = 3'd3;
  localparam logic [2:0] EXC_DIVZ = 3'd4;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     result;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
  } entry_t;

  // Priority: div-by-zero, then trapping overflow, then misaligned access (load over store).
  function automatic logic [2:0] decode_fault(input logic divz, input logic ovf,
                                              input logic inva, input logic ovf_trap,
                                              input logic mem_read, input logic mem_write);
    logic [2:0] cause;
    cause = EXC_NONE;
    if (divz)                                 cause = EXC_DIVZ;
    else if (ovf && ovf_trap)                 cause = EXC_OVF;
    else if (inva && (mem_read || mem_write)) cause = mem_read ? EXC_LMIS : EXC_SMIS;
    return cause;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Upstream (ALU side) and downstream (MEM side) handshake bundle of the EX->MEM stage.
// master: the surrounding pipeline; slave: the stage itself.
interface ex_mem_stage_if;

  logic                              in_valid;
  logic                              in_ready;
  logic [ex_mem_pkg::DATA_W-1:0]     in_result;
  logic [ex_mem_pkg::STATUS_W-1:0]   in_status;
  logic [ex_mem_pkg::DATA_W-1:0]     in_store_data;
  logic [ex_mem_pkg::DATA_W-1:0]     in_pc;
  logic [ex_mem_pkg::REG_ADDR_W-1:0] in_rd;
  logic                              in_mem_read;
  logic                              in_mem_write;
  logic                              in_reg_write;
  logic                              in_ovf_trap;

  logic                              out_valid;
  logic                              out_ready;
  logic [ex_mem_pkg::DATA_W-1:0]     out_result;
  logic [ex_mem_pkg::DATA_W-1:0]     out_store_data;
  logic [ex_mem_pkg::REG_ADDR_W-1:0] out_rd;
  logic                              out_mem_read;
  logic                              out_mem_write;
  logic                              out_reg_write;

  modport master (
    output in_valid, in_result, in_status, in_store_data, in_pc, in_rd,
           in_mem_read, in_mem_write, in_reg_write, in_ovf_trap, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd,
           out_mem_read, out_mem_write, out_reg_write
  );

  modport slave (
    input  in_valid, in_result, in_status, in_store_data, in_pc, in_rd,
           in_mem_read, in_mem_write, in_reg_write, in_ovf_trap, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd,
           out_mem_read, out_mem_write, out_reg_write
  );

endinterface

// File: rtl/ex_mem_stage_skid.sv
// Generic 2-entry valid/ready skid buffer: a main (output) register plus one overflow slot.
// push_ready depends only on register state; flush empties both slots.
module ex_mem_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         push_ready,
  output logic         pop_valid,
  output logic [W-1:0] pop_data,
  input  logic         pop_ready
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         push;
  logic         pop;

  assign push_ready = !skid_v_q;
  assign push       = push_valid && push_ready;
  assign pop        = main_v_q && pop_ready;
  assign pop_valid  = main_v_q;
  assign pop_data   = main_q;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (pop || !main_v_q) begin
      // Main slot frees up: the older skid entry always moves in before new input.
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = push;
        if (push) main_d = push_data;
      end
    end else if (push) begin
      skid_d   = push_data;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: skid-buffered handshake, precise exception capture with side-effect
// squashing, and optional performance counters enabled by defining EX_MEM_PERF_EN.
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  ex_mem_stage_if.slave        bus,
  input  logic                 flush,
  output logic                 exc_pending,
  output logic [2:0]           exc_cause,
  output logic [DATA_W-1:0]    exc_epc,
  input  logic                 exc_ack,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_exc_cnt
);

  state_e              state_q;
  logic [2:0]          cause_q;
  logic [DATA_W-1:0]   epc_q;
  logic                skid_ready;
  logic                accept;
  logic [2:0]          fault_cause;
  logic                fault;
  entry_t              in_entry;
  entry_t              out_entry;
  logic                unused_status;

  assign bus.in_ready = skid_ready && (state_q == RUN) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  assign fault_cause = decode_fault(bus.in_status[ST_DIVZ], bus.in_status[ST_OVF],
                                    bus.in_status[ST_INVA], bus.in_ovf_trap,
                                    bus.in_mem_read, bus.in_mem_write);
  assign fault       = (fault_cause != EXC_NONE);
  assign unused_status = ^{bus.in_status[ST_ZERO], bus.in_status[ST_CARRY], bus.in_status[ST_NEG],
                           bus.in_status[ST_RSV1], bus.in_status[ST_RSV0]};

  // A faulting instruction still flows downstream, but with every side effect squashed.
  assign in_entry = '{result:     bus.in_result,
                      store_data: bus.in_store_data,
                      rd:         bus.in_rd,
                      mem_read:   bus.in_mem_read  && !fault,
                      mem_write:  bus.in_mem_write && !fault,
                      reg_write:  bus.in_reg_write && !fault};

  ex_mem_skid #(.W($bits(entry_t))) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (accept),
    .push_data  (in_entry),
    .push_ready (skid_ready),
    .pop_valid  (bus.out_valid),
    .pop_data   (out_entry),
    .pop_ready  (bus.out_ready)
  );

  assign bus.out_result     = out_entry.result;
  assign bus.out_store_data = out_entry.store_data;
  assign bus.out_rd         = out_entry.rd;
  assign bus.out_mem_read   = out_entry.mem_read;
  assign bus.out_mem_write  = out_entry.mem_write;
  assign bus.out_reg_write  = out_entry.reg_write;

  // Intake is closed in TRAP, so a new fault and an acknowledge can never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cause_q <= EXC_NONE;
      epc_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept && fault) begin
            state_q <= TRAP;
            cause_q <= fault_cause;
            epc_q   <= bus.in_pc;
          end
        end
        TRAP: begin
          if (exc_ack) begin
            state_q <= RUN;
            cause_q <= EXC_NONE;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign exc_pending = (state_q == TRAP);
  assign exc_cause   = cause_q;
  assign exc_epc     = epc_q;

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] exc_cnt_q, exc_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, bus.out_valid && !bus.out_ready);
    exc_cnt_d   = sat_inc(exc_cnt_q, accept && fault);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      exc_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      exc_cnt_q   <= exc_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_exc_cnt   = exc_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_exc_cnt   = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios with literal expectations followed by randomized
// traffic, all checked every cycle against a queue-based behavioural model.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush = 1'b0;
  logic              exc_ack = 1'b0;
  logic              exc_pending;
  logic [2:0]        exc_cause;
  logic [DATA_W-1:0] exc_epc;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_exc_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ex_mem_stage_if bus();

  ex_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .flush          (flush),
    .exc_pending    (exc_pending),
    .exc_cause      (exc_cause),
    .exc_epc        (exc_epc),
    .exc_ack        (exc_ack),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_exc_cnt   (perf_exc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    bit          mr, mw, rw;
  } exp_t;

  exp_t        q[$];
  bit          m_trap = 0;
  logic [2:0]  m_cause = 3'd0;
  logic [31:0] m_epc = 32'd0;
  longint      m_stall = 0;
  longint      m_exc = 0;

  function automatic bit m_rdy();
    return (q.size() < 2) && !m_trap && !flush;
  endfunction

  function automatic logic [2:0] ref_cause(input logic [7:0] st, input bit trap_en,
                                           input bit mr, input bit mw);
    if (st[2])                 return 3'd4;
    if (st[6] && trap_en)      return 3'd1;
    if (st[3] && (mr || mw))   return mr ? 3'd2 : 3'd3;
    return 3'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit         acc;
    logic [2:0] c;
    exp_t       e;
    if (!rst_n) begin
      q.delete();
      m_trap = 0; m_cause = 0; m_epc = 0; m_stall = 0; m_exc = 0;
    end else begin
      acc = bus.in_valid && m_rdy();
      c   = ref_cause(bus.in_status, bus.in_ovf_trap, bus.in_mem_read, bus.in_mem_write);
      if (q.size() > 0 && !bus.out_ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
        if (acc) begin
          e.result = bus.in_result; e.store_data = bus.in_store_data; e.rd = bus.in_rd;
          e.mr = bus.in_mem_read  && (c == 0);
          e.mw = bus.in_mem_write && (c == 0);
          e.rw = bus.in_reg_write && (c == 0);
          q.push_back(e);
        end
      end
      if (m_trap && exc_ack) begin
        m_trap = 0; m_cause = 0;
      end else if (acc && c != 0) begin
        m_trap = 1; m_cause = c; m_epc = bus.in_pc; m_exc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("in_ready", bus.in_ready, m_rdy());
    if (q.size() > 0) begin
      chk("out_result", bus.out_result, q[0].result);
      chk("out_store_data", bus.out_store_data, q[0].store_data);
      chk("out_rd", bus.out_rd, q[0].rd);
      chk("out_mem_read", bus.out_mem_read, q[0].mr);
      chk("out_mem_write", bus.out_mem_write, q[0].mw);
      chk("out_reg_write", bus.out_reg_write, q[0].rw);
    end
    chk("exc_pending", exc_pending, m_trap);
    chk("exc_cause", exc_cause, m_cause);
    chk("exc_epc", exc_epc, m_epc);
`ifdef EX_MEM_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, m_stall);
    chk("perf_exc_cnt", perf_exc_cnt, m_exc);
`else
    chk("perf_stall_cnt", perf_stall_cnt, 0);
    chk("perf_exc_cnt", perf_exc_cnt, 0);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] res, input logic [7:0] st,
                       input logic [31:0] pc, input bit mr, input bit mw, input bit rw,
                       input bit ot);
    bus.in_valid      = v;
    bus.in_result     = res;
    bus.in_status     = st;
    bus.in_store_data = res ^ 32'hA5A5_0000;
    bus.in_pc         = pc;
    bus.in_rd         = res[4:0];
    bus.in_mem_read   = mr;
    bus.in_mem_write  = mw;
    bus.in_reg_write  = rw;
    bus.in_ovf_trap   = ot;
  endtask

  task automatic idle();
    drive(0, 32'h0, 8'h0, 32'h0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_exc_pending", exc_pending, 0);
    chk("rst_exc_cause", exc_cause, 0);
    chk("rst_exc_epc", exc_epc, 0);
    rst_n = 1'b1;

    // 1: back-to-back stream, no bubbles
    drive(1, 32'h10, 8'h00, 32'h100, 0, 0, 1, 1); step();
    chk("t1_a", bus.out_result, 32'h10);
    drive(1, 32'h14, 8'h00, 32'h104, 0, 0, 1, 1); step();
    chk("t1_b", bus.out_result, 32'h14);
    chk("t1_b_valid", bus.out_valid, 1);
    drive(1, 32'h18, 8'h00, 32'h108, 0, 0, 1, 1); step();
    chk("t1_c", bus.out_result, 32'h18);
    idle(); step();
    chk("t1_drain", bus.out_valid, 0);

    // 2: backpressure with skid, FIFO order on release
    bus.out_ready = 1'b0;
    drive(1, 32'h20, 8'h00, 32'h110, 0, 0, 1, 0); step();
    chk("t2_hold_a", bus.out_result, 32'h20);
    chk("t2_ready1", bus.in_ready, 1);
    drive(1, 32'h24, 8'h00, 32'h114, 0, 0, 1, 0); step();
    chk("t2_ready0", bus.in_ready, 0);
    drive(1, 32'h28, 8'h00, 32'h118, 0, 0, 1, 0); step();
    chk("t2_still_a", bus.out_result, 32'h20);
    chk("t2_c_blocked", bus.in_ready, 0);
    bus.out_ready = 1'b1; step();
    chk("t2_b", bus.out_result, 32'h24);
    step();
    chk("t2_c", bus.out_result, 32'h28);
    idle(); step();

    // 3: misaligned load
    drive(1, 32'h1002, 8'h08, 32'h400, 1, 0, 1, 0); step();
    chk("t3_valid", bus.out_valid, 1);
    chk("t3_mem_read", bus.out_mem_read, 0);
    chk("t3_cause", exc_cause, 3'd2);
    chk("t3_epc", exc_epc, 32'h400);
    chk("t3_model_cause", m_cause, 3'd2);
    idle(); step(); step();
    chk("t3_closed", bus.in_ready, 0);
    exc_ack = 1'b1; step(); exc_ack = 1'b0;
    chk("t3_ack_pending", exc_pending, 0);
    chk("t3_ack_cause", exc_cause, 0);
    chk("t3_ack_epc", exc_epc, 32'h400);
    chk("t3_reopen", bus.in_ready, 1);

    // 4: overflow only traps when ovf_trap is set
    drive(1, 32'h30, 8'h40, 32'h500, 0, 0, 1, 0); step();
    chk("t4_rw_pass", bus.out_reg_write, 1);
    chk("t4_no_exc", exc_pending, 0);
    drive(1, 32'h34, 8'h40, 32'h504, 0, 0, 1, 1); step();
    chk("t4_cause", exc_cause, 3'd1);
    chk("t4_rw_gated", bus.out_reg_write, 0);
    chk("t4_epc", exc_epc, 32'h504);
    idle(); exc_ack = 1'b1; step(); exc_ack = 1'b0;

    // 5: div-by-zero priority, then flush of a full buffer
    drive(1, 32'h38, 8'h44, 32'h508, 0, 0, 1, 1); step();
    chk("t5_cause", exc_cause, 3'd4);
    idle(); exc_ack = 1'b1; step(); exc_ack = 1'b0;
    bus.out_ready = 1'b0;
    drive(1, 32'h40, 8'h00, 32'h600, 0, 1, 0, 0); step();
    drive(1, 32'h44, 8'h00, 32'h604, 0, 1, 0, 0); step();
    chk("t5_full", bus.in_ready, 0);
    flush = 1'b1;
    drive(1, 32'h48, 8'h00, 32'h608, 0, 1, 0, 0); step();
    chk("t5_flushed", bus.out_valid, 0);
    flush = 1'b0; idle(); step();
    chk("t5_discarded", bus.out_valid, 0);
    bus.out_ready = 1'b1;

    // 6: performance counters from a clean reset, then mid-stream reset
    #2 rst_n = 1'b0; #2 rst_n = 1'b1;
    step();
    bus.out_ready = 1'b0;
    drive(1, 32'h50, 8'h00, 32'h700, 0, 0, 1, 0); step();
    idle(); repeat (5) step();
    bus.out_ready = 1'b1; step();
    drive(1, 32'h60, 8'h04, 32'h710, 0, 0, 1, 0); step();
    idle(); exc_ack = 1'b1; step(); exc_ack = 1'b0;
    drive(1, 32'h64, 8'h04, 32'h714, 0, 0, 1, 0); step();
    idle(); exc_ack = 1'b1; step(); exc_ack = 1'b0;
`ifdef EX_MEM_PERF_EN
    chk("t6_stall", perf_stall_cnt, 32'd5);
    chk("t6_exc", perf_exc_cnt, 32'd2);
`else
    chk("t6_stall", perf_stall_cnt, 32'd0);
    chk("t6_exc", perf_exc_cnt, 32'd0);
`endif
    chk("t6_model_stall", m_stall, 5);
    bus.out_ready = 1'b0;
    drive(1, 32'h70, 8'h00, 32'h720, 0, 0, 1, 0); step();
    drive(1, 32'h74, 8'h04, 32'h724, 0, 0, 1, 0); step();
    chk("t6_pre_pending", exc_pending, 1);
    #2 rst_n = 1'b0; #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_ready", bus.in_ready, 1);
    chk("t6_rst_result", bus.out_result, 0);
    chk("t6_rst_pending", exc_pending, 0);
    chk("t6_rst_cause", exc_cause, 0);
    chk("t6_rst_epc", exc_epc, 0);
    chk("t6_rst_stall", perf_stall_cnt, 0);
    chk("t6_rst_exc", perf_exc_cnt, 0);
    idle(); step(); rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] st;
      st = 8'($urandom) & 8'hB3;
      if ($urandom_range(0, 19) == 0) st[2] = 1'b1;
      if ($urandom_range(0, 9) == 0)  st[6] = 1'b1;
      if ($urandom_range(0, 9) == 0)  st[3] = 1'b1;
      drive($urandom_range(0, 3) != 0, $urandom, st, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.in_store_data = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 31) == 0);
      exc_ack = ($urandom_range(0, 3) == 0);
      step();
    end
    idle(); flush = 1'b0; exc_ack = 1'b0; bus.out_ready = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
